// File: rtl/pushbutton_bank.sv
// pushbutton_bank: multi-channel pushbutton debouncer.
// Each channel: polarity fix, N_SYNC-deep synchroniser, deferring debounce,
// toggle state, press/release pulses, long-press level and (optionally)
// auto-repeat pulses while a long press is held.
// Optional feature macro: PUSHBUTTON_BANK_REPEAT_EN adds the per-channel
// auto-repeat counter; without it o_repeat is constant 0.
// i_cg is a clock enable: when low every flop in the block holds.
module pushbutton_bank #(
  parameter int                   N_CHANNEL       = 4,
  parameter int                   DEBOUNCE_CYCLES = 31,
  parameter int                   N_SYNC          = 2,
  parameter int                   LONG_CYCLES     = 1023,
  parameter int                   REPEAT_CYCLES   = 255,
  parameter logic [N_CHANNEL-1:0] ACTIVE_LOW      = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_cg,
  input  logic [N_CHANNEL-1:0] i_button,
  output logic [N_CHANNEL-1:0] o_debounced,
  output logic [N_CHANNEL-1:0] o_toggle,
  output logic [N_CHANNEL-1:0] o_press,
  output logic [N_CHANNEL-1:0] o_release,
  output logic [N_CHANNEL-1:0] o_long,
  output logic [N_CHANNEL-1:0] o_repeat,
  output logic                 o_any
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [CNT_W-1:0]  DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

  // Elaboration-time guard against parameter values the logic cannot honour.
  if (N_CHANNEL < 1 || DEBOUNCE_CYCLES < 2 || N_SYNC < 2 ||
      LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("pushbutton_bank: illegal parameter value");
  end

  // Pressed polarity is normalised before the synchroniser so that every
  // downstream stage works with 1 = pressed.
  logic [N_CHANNEL-1:0] pressed;
  assign pressed = i_button ^ ACTIVE_LOW;

  logic [N_SYNC-1:0]    sync_q [N_CHANNEL];
  logic [N_SYNC-1:0]    sync_d [N_CHANNEL];
  logic [CNT_W-1:0]     cnt_q  [N_CHANNEL];
  logic [CNT_W-1:0]     cnt_d  [N_CHANNEL];
  logic [HOLD_W-1:0]    hold_q [N_CHANNEL];
  logic [HOLD_W-1:0]    hold_d [N_CHANNEL];
  logic [N_CHANNEL-1:0] deb_q, deb_d;
  logic [N_CHANNEL-1:0] tog_q, tog_d;
  logic [N_CHANNEL-1:0] press_q, press_d;
  logic [N_CHANNEL-1:0] release_q, release_d;
  logic [N_CHANNEL-1:0] long_w;

  // Next-state for synchroniser, debounce counter, event pulses and hold counter.
  always_comb begin
    for (int i = 0; i < N_CHANNEL; i++) begin
      sync_d[i]    = sync_q[i];
      cnt_d[i]     = cnt_q[i];
      hold_d[i]    = hold_q[i];
      deb_d[i]     = deb_q[i];
      tog_d[i]     = tog_q[i];
      press_d[i]   = press_q[i];
      release_d[i] = release_q[i];
      if (i_cg) begin
        // New sample enters at the top; bit 0 is the settled output.
        sync_d[i]    = {pressed[i], sync_q[i][N_SYNC-1:1]};
        press_d[i]   = 1'b0;
        release_d[i] = 1'b0;
        if (sync_q[i][0] != sync_q[i][1]) begin
          // Level still moving through the synchroniser: restart the window.
          cnt_d[i] = '0;
        end else if (sync_q[i][0] == deb_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == DEB_MAX) begin
          cnt_d[i] = '0;
          deb_d[i] = sync_q[i][0];
          if (sync_q[i][0]) begin
            press_d[i] = 1'b1;
            tog_d[i]   = ~tog_q[i];
          end else begin
            release_d[i] = 1'b1;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
        // Hold counter measures how long the debounced press has lasted.
        if (!deb_q[i]) begin
          hold_d[i] = '0;
        end else if (hold_q[i] != HOLD_MAX) begin
          hold_d[i] = hold_q[i] + HOLD_W'(1);
        end
      end
    end
  end

  // Long-press level; drops in the same cycle the debounced state drops.
  always_comb begin
    long_w = '0;
    for (int i = 0; i < N_CHANNEL; i++) begin
      long_w[i] = deb_q[i] && (hold_q[i] == HOLD_MAX);
    end
  end

  // State registers for the debounce path.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_CHANNEL; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
        hold_q[i] <= '0;
      end
      deb_q     <= '0;
      tog_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      for (int i = 0; i < N_CHANNEL; i++) begin
        sync_q[i] <= sync_d[i];
        cnt_q[i]  <= cnt_d[i];
        hold_q[i] <= hold_d[i];
      end
      deb_q     <= deb_d;
      tog_q     <= tog_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef PUSHBUTTON_BANK_REPEAT_EN
  localparam int               REP_W   = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES);

  logic [REP_W-1:0]     rep_q [N_CHANNEL];
  logic [REP_W-1:0]     rep_d [N_CHANNEL];
  logic [N_CHANNEL-1:0] repeat_q, repeat_d;

  // Repeat counter runs only while the long-press level is up; each wrap
  // produces one pulse, so pulses are REPEAT_CYCLES+1 cycles apart.
  always_comb begin
    for (int i = 0; i < N_CHANNEL; i++) begin
      rep_d[i]    = rep_q[i];
      repeat_d[i] = repeat_q[i];
      if (i_cg) begin
        repeat_d[i] = 1'b0;
        if (!long_w[i]) begin
          rep_d[i] = '0;
        end else if (rep_q[i] == REP_MAX) begin
          rep_d[i]    = '0;
          repeat_d[i] = 1'b1;
        end else begin
          rep_d[i] = rep_q[i] + REP_W'(1);
        end
      end
    end
  end

  // State registers for the repeat path.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_CHANNEL; i++) begin
        rep_q[i] <= '0;
      end
      repeat_q <= '0;
    end else begin
      for (int i = 0; i < N_CHANNEL; i++) begin
        rep_q[i] <= rep_d[i];
      end
      repeat_q <= repeat_d;
    end
  end

  // Gating with the long level kills a pending pulse the moment the key is released.
  assign o_repeat = repeat_q & long_w;
`else
  assign o_repeat = '0;
`endif

  assign o_debounced = deb_q;
  assign o_toggle    = tog_q;
  assign o_press     = press_q;
  assign o_release   = release_q;
  assign o_long      = long_w;
  assign o_any       = |deb_q;

endmodule

// File: tb/tb_pushbutton_bank.sv
// Testbench for pushbutton_bank: 4 channels, 31-cycle debounce, 2-stage
// synchroniser, long press after 8 cycles, repeat period 4, channel 2 active-low.
module tb_pushbutton_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cg = 1'b1;
  logic [3:0] btn = 4'b0100;

  logic [3:0] o_debounced, o_toggle, o_press, o_release, o_long, o_repeat;
  logic       o_any;

  pushbutton_bank #(
    .N_CHANNEL      (4),
    .DEBOUNCE_CYCLES(31),
    .N_SYNC         (2),
    .LONG_CYCLES    (8),
    .REPEAT_CYCLES  (3),
    .ACTIVE_LOW     (4'b0100)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_cg       (cg),
    .i_button   (btn),
    .o_debounced(o_debounced),
    .o_toggle   (o_toggle),
    .o_press    (o_press),
    .o_release  (o_release),
    .o_long     (o_long),
    .o_repeat   (o_repeat),
    .o_any      (o_any)
  );

  // Clock
  always #5 clk = ~clk;

`ifdef PUSHBUTTON_BANK_REPEAT_EN
  localparam logic [3:0] REP0 = 4'b0001;
`else
  localparam logic [3:0] REP0 = 4'b0000;
`endif

  localparam logic [3:0] B0 = 4'b0100; // nothing pressed

  typedef struct {
    logic [3:0]  btn;
    int          n;
    logic [24:0] exp;
  } vec_t;

  vec_t        vecs[21];
  logic [24:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  wire [24:0] act = {o_debounced, o_toggle, o_press, o_release, o_long, o_repeat, o_any};

  function automatic logic [24:0] pk(input logic [3:0] d, input logic [3:0] t,
                                     input logic [3:0] p, input logic [3:0] r,
                                     input logic [3:0] l, input logic [3:0] rp,
                                     input logic a);
    return {d, t, p, r, l, rp, a};
  endfunction

  function automatic vec_t mk(input logic [3:0] b, input int n, input logic [24:0] e);
    vec_t v;
    v.btn = b;
    v.n   = n;
    v.exp = e;
    return v;
  endfunction

  // Advance n clock edges; inputs change and outputs are sampled 1 ns after an edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [24:0] e);
    exp_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare against current outputs.
  task automatic check(input string name);
    logic [24:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard queue empty, got %h", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_err++;
        $display("FAIL %s: got deb=%b tog=%b prs=%b rel=%b lng=%b rep=%b any=%b, want %h (got %h)",
                 name, o_debounced, o_toggle, o_press, o_release, o_long, o_repeat, o_any, e, act);
      end
    end
  endtask

  initial begin
    // Vector table: drive btn, advance n edges, then compare.
    vecs[0]  = mk(B0,      5,  pk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0));
    vecs[1]  = mk(4'b0101, 33, pk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0));
    vecs[2]  = mk(4'b0101, 1,  pk(4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1));
    vecs[3]  = mk(4'b0101, 1,  pk(4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1));
    vecs[4]  = mk(4'b0101, 6,  pk(4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1));
    vecs[5]  = mk(4'b0101, 1,  pk(4'h1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 1'b1));
    vecs[6]  = mk(4'b0101, 3,  pk(4'h1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 1'b1));
    vecs[7]  = mk(4'b0101, 1,  pk(4'h1, 4'h1, 4'h0, 4'h0, 4'h1, REP0, 1'b1));
    vecs[8]  = mk(4'b0101, 1,  pk(4'h1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 1'b1));
    vecs[9]  = mk(4'b0101, 3,  pk(4'h1, 4'h1, 4'h0, 4'h0, 4'h1, REP0, 1'b1));
    vecs[10] = mk(4'b0101, 4,  pk(4'h1, 4'h1, 4'h0, 4'h0, 4'h1, REP0, 1'b1));
    vecs[11] = mk(B0,      33, pk(4'h1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 1'b1));
    vecs[12] = mk(B0,      1,  pk(4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0));
    vecs[13] = mk(B0,      1,  pk(4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0));
    vecs[14] = mk(4'b0110, 20, pk(4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0));
    vecs[15] = mk(B0,      40, pk(4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0));
    vecs[16] = mk(4'b0101, 34, pk(4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1));
    vecs[17] = mk(B0,      34, pk(4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0));
    vecs[18] = mk(4'b0000, 33, pk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0));
    vecs[19] = mk(4'b0000, 1,  pk(4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 1'b1));
    vecs[20] = mk(B0,      34, pk(4'h0, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0, 1'b0));

    // Reset block
    rst_n = 1'b0;
    cg    = 1'b1;
    btn   = B0;
    #2;
    push('0);
    check("in_reset");
    tick(3);
    push('0);
    check("in_reset_clocked");
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 21; i++) begin
      btn = vecs[i].btn;
      push(vecs[i].exp);
      tick(vecs[i].n);
      check($sformatf("vec%0d", i));
    end

    // Channel 3 toggling every cycle never settles
    for (int i = 0; i < 60; i++) begin
      btn[3] = ~btn[3];
      push(pk(4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0));
      tick(1);
      check($sformatf("chatter%0d", i));
    end
    push(pk(4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0));
    tick(40);
    check("chatter_settled");

    // Clock enable low for 10 cycles mid-debounce stretches latency by 10
    btn = 4'b0101;
    push(pk(4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0));
    tick(10);
    check("cg_before");
    cg = 1'b0;
    tick(10);
    cg = 1'b1;
    push(pk(4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0));
    tick(23);
    check("cg_not_yet");
    push(pk(4'h1, 4'h5, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1));
    tick(1);
    check("cg_press");
    cg = 1'b0;
    push(pk(4'h1, 4'h5, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1));
    tick(3);
    check("cg_pulse_held");
    cg = 1'b1;
    push(pk(4'h1, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1));
    tick(1);
    check("cg_pulse_end");
    push(pk(4'h1, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1));
    tick(3);
    check("mid_hold");

    // Asynchronous reset mid-hold: outputs clear at once, progress discarded
    #2;
    rst_n = 1'b0;
    #1;
    push('0);
    check("async_reset");
    tick(2);
    push('0);
    check("reset_held");
    rst_n = 1'b1;
    push('0);
    tick(33);
    check("rerelease_wait");
    push(pk(4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1));
    tick(1);
    check("rerelease_press");
    push(pk(4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1));
    tick(7);
    check("rehold_short");
    push(pk(4'h1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 1'b1));
    tick(1);
    check("rehold_long");

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
